hilo_div_ctrl: RTL and testbench
================================

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: div_req  input  1  decoded signed divide, held high by the core while stalled.
REQ-004 SHALL have port: divu_req  input  1  decoded unsigned divide, held high while stalled; div_req and divu_req are never both high.
REQ-005 SHALL have port: flush  input  1  abort any in-flight divide (exception/eret).
REQ-006 SHALL have port: rs_val, rt_val  input  32 each  dividend and divisor from the register file.
REQ-007 SHALL have ports to the shared divider core: dv_start out 1 (one-cycle pulse), dv_signed out 1, dv_dividend out 32, dv_divisor out 32, dv_busy in 1, dv_q in 32, dv_r in 32.
REQ-008 SHALL have port: stall  output  1  hold PC and the request while high.
REQ-009 SHALL have ports: hilo_we out 1, hi_wdata out 32, lo_wdata out 32; HI takes the remainder, LO the quotient.
REQ-010 SHALL have port: timeout_err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-011 States SHALL be IDLE, START, WAIT and DONE, encoded in 2 bits.
REQ-012 IDLE with (div_req|divu_req) & !flush SHALL latch rs_val, rt_val and signedness, then go to START.
REQ-013 START SHALL drive dv_start=1 for exactly one cycle, then go to WAIT.
REQ-014 dv_dividend, dv_divisor and dv_signed SHALL come from the latches and stay stable from START until DONE.
REQ-015 WAIT SHALL go to DONE on the first cycle with dv_busy=0, after at least one WAIT cycle.
- dv_q and dv_r are captured into the result registers on that transition.
REQ-016 A 6-bit watchdog SHALL clear on entering WAIT and increment each WAIT cycle.
- At count 47 with dv_busy still 1: go to DONE, pulse timeout_err, write HI=LO=0.
REQ-017 DONE SHALL assert hilo_we=1 for exactly one cycle with the captured results, then return to IDLE.
REQ-018 stall SHALL be combinational: (div_req|divu_req) & (state!=DONE) & !flush.
- stall is therefore 0 in DONE, and the PC advances that cycle.
REQ-019 A back-to-back divide request seen in IDLE immediately after DONE SHALL start a new operation with no lost cycle beyond IDLE.
REQ-020 flush in any state SHALL force IDLE on the next edge.
- hilo_we=0 and dv_start=0 in that cycle; a divider still busy is ignored.
- In IDLE, no new request is accepted while dv_busy=1.
REQ-021 Minimum latency request-to-hilo_we SHALL be (divider latency + 3) cycles.

Reset
REQ-022 rst=1 SHALL asynchronously force: state=IDLE, watchdog=0, all latches=0, dv_start=0, hilo_we=0, timeout_err=0, hi_wdata=lo_wdata=0.
- stall then follows REQ-018.
REQ-023 Reset asserted mid-operation SHALL discard the operation with no HI/LO write after release.

Configuration
REQ-024 With macro HILO_DIV_ZERO_BYPASS_EN defined, a request with rt_val==0 SHALL go IDLE->DONE directly.
- No dv_start is issued.
- Writes LO=32'hFFFFFFFF and HI=rs_val.
- Latency is 1 cycle of stall.
REQ-025 Without HILO_DIV_ZERO_BYPASS_EN, a divisor of zero SHALL follow the normal START/WAIT path with the divider's results.

Verification
REQ-026 divu_req, rs=100, rt=7, divider latency 33 -> one dv_start pulse, stall high 35 cycles, hilo_we pulse with LO=14, HI=2.
REQ-027 div_req, rs=32'hFFFFFFF9 (-7), rt=2 -> dv_signed=1, LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
REQ-028 flush raised in the 10th WAIT cycle -> IDLE next edge, no hilo_we, stall=0; a new request is accepted only after dv_busy falls.
REQ-029 dv_busy forced high permanently -> timeout_err and hilo_we pulse together after 47 WAIT cycles, HI=LO=0, FSM in IDLE.
REQ-030 rs=5, rt=0 with HILO_DIV_ZERO_BYPASS_EN -> no dv_start, hilo_we within 2 cycles, LO=32'hFFFFFFFF, HI=5; without the macro -> normal path.
REQ-031 rst pulsed during WAIT -> all outputs 0 asynchronously, no write after release; two consecutive divu requests -> two distinct hilo_we pulses with the correct results.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// Sequencer between the decode stage and a shared multi-cycle divider; writes HI/LO on completion.
// Optional macro HILO_DIV_ZERO_BYPASS_EN: a zero divisor skips the divider and writes LO=all-ones, HI=dividend.
module hilo_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req,
    input  logic        divu_req,
    input  logic        flush,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        dv_start,
    output logic        dv_signed,
    output logic [31:0] dv_dividend,
    output logic [31:0] dv_divisor,
    input  logic        dv_busy,
    input  logic [31:0] dv_q,
    input  logic [31:0] dv_r,
    output logic        stall,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        timeout_err
);

    // state | meaning
    // IDLE  | waiting for a divide request while the divider is free
    // START | one-cycle start pulse to the divider
    // WAIT  | divider running, watchdog counting
    // DONE  | one-cycle HI/LO write, core released
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [5:0] WD_LIMIT = 6'd47;

    state_t      state, state_nxt;
    logic [5:0]  wd_cnt, wd_nxt, wd_inc;
    logic [31:0] rs_lat, rs_nxt;
    logic [31:0] rt_lat, rt_nxt;
    logic        sgn_lat, sgn_nxt;
    logic [31:0] hi_res, hi_nxt;
    logic [31:0] lo_res, lo_nxt;
    logic        to_flag, to_nxt;
    logic        req;

    assign req    = div_req | divu_req;
    assign wd_inc = wd_cnt + 6'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wd_cnt  <= '0;
            rs_lat  <= '0;
            rt_lat  <= '0;
            sgn_lat <= 1'b0;
            hi_res  <= '0;
            lo_res  <= '0;
            to_flag <= 1'b0;
        end else begin
            state   <= state_nxt;
            wd_cnt  <= wd_nxt;
            rs_lat  <= rs_nxt;
            rt_lat  <= rt_nxt;
            sgn_lat <= sgn_nxt;
            hi_res  <= hi_nxt;
            lo_res  <= lo_nxt;
            to_flag <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wd_nxt    = wd_cnt;
        rs_nxt    = rs_lat;
        rt_nxt    = rt_lat;
        sgn_nxt   = sgn_lat;
        hi_nxt    = hi_res;
        lo_nxt    = lo_res;
        to_nxt    = to_flag;
        if (flush) begin
            // abandoned divider keeps running; IDLE holds off until it drops busy
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !dv_busy) begin
                        rs_nxt    = rs_val;
                        rt_nxt    = rt_val;
                        sgn_nxt   = div_req;
                        to_nxt    = 1'b0;
                        state_nxt = START;
`ifdef HILO_DIV_ZERO_BYPASS_EN
                        if (rt_val == 32'd0) begin
                            hi_nxt    = rs_val;
                            lo_nxt    = 32'hFFFF_FFFF;
                            state_nxt = DONE;
                        end
`endif
                    end
                end
                START: begin
                    wd_nxt    = '0;
                    state_nxt = WAIT;
                end
                WAIT: begin
                    wd_nxt = wd_inc;
                    if (!dv_busy) begin
                        hi_nxt    = dv_r;
                        lo_nxt    = dv_q;
                        state_nxt = DONE;
                    end else if (wd_inc == WD_LIMIT) begin
                        hi_nxt    = '0;
                        lo_nxt    = '0;
                        to_nxt    = 1'b1;
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign stall       = req && (state != DONE) && !flush;
    assign dv_start    = (state == START) && !flush;
    assign hilo_we     = (state == DONE) && !flush;
    assign timeout_err = (state == DONE) && to_flag && !flush;
    assign dv_signed   = sgn_lat;
    assign dv_dividend = rs_lat;
    assign dv_divisor  = rt_lat;
    assign hi_wdata    = hi_res;
    assign lo_wdata    = lo_res;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: table vectors, hand-built flush/reset/timeout sequences, random ops.
// Divider is modelled as busy for (lat-1) cycles after the start edge, so a normal op writes HI/LO lat+2 cycles after the request.
module tb_hilo_div_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        div_req, divu_req, flush;
    logic [31:0] rs_val, rt_val;
    logic        dv_start, dv_signed, dv_busy;
    logic [31:0] dv_dividend, dv_divisor, dv_q, dv_r;
    logic        stall, hilo_we, timeout_err;
    logic [31:0] hi_wdata, lo_wdata;

    int errors = 0;
    int checks = 0;

    hilo_div_ctrl dut (
        .clk(clk), .rst(rst), .div_req(div_req), .divu_req(divu_req), .flush(flush),
        .rs_val(rs_val), .rt_val(rt_val), .dv_start(dv_start), .dv_signed(dv_signed),
        .dv_dividend(dv_dividend), .dv_divisor(dv_divisor), .dv_busy(dv_busy),
        .dv_q(dv_q), .dv_r(dv_r), .stall(stall), .hilo_we(hilo_we),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

`ifdef HILO_DIV_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // returns {remainder, quotient}; zero divisor gives q=all ones, r=dividend
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // external divider model
    int          div_lat = 5;
    int          bcnt = 0;
    logic [31:0] q_reg = '0, r_reg = '0;
    always @(posedge clk) begin
        if (dv_start) begin
            bcnt <= div_lat - 1;
            {r_reg, q_reg} <= ref_div(dv_dividend, dv_divisor, dv_signed);
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end
    end
    assign dv_busy = (bcnt != 0);
    assign dv_q    = q_reg;
    assign dv_r    = r_reg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_div_free();
        int n = 0;
        while (dv_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("div_free_bound", dv_busy, 1'b0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int lat,
                         input logic use_exp, input logic [31:0] ehi_in, input logic [31:0] elo_in,
                         input logic b2b, input string tag);
        logic [31:0] ehi, elo;
        logic        byp, tmo, seen;
        int          exp_c, stall_cnt, starts;
        byp = BYPASS && (b == 32'd0);
        tmo = !byp && (lat >= 48);
        if (use_exp) {ehi, elo} = {ehi_in, elo_in};
        else         {ehi, elo} = ref_div(a, b, sgn);
        if (tmo) begin
            ehi = '0;
            elo = '0;
        end
        exp_c = byp ? 1 : (tmo ? 49 : lat + 2);
        if (!b2b) @(negedge clk);
        div_lat  = lat;
        rs_val   = a;
        rt_val   = b;
        div_req  = sgn;
        divu_req = !sgn;
        if (b2b) begin
            @(negedge clk);
            chk({tag, "_b2b_gap_we"}, hilo_we, 1'b0);
        end
        #1;
        stall_cnt = stall;
        starts    = dv_start;
        seen      = 1'b0;
        for (int c = 1; c <= 80 && !seen; c++) begin
            @(negedge clk);
            if (hilo_we) begin
                seen = 1'b1;
                chk({tag, "_cycle"}, c, exp_c);
                chk({tag, "_hi"}, hi_wdata, ehi);
                chk({tag, "_lo"}, lo_wdata, elo);
                chk({tag, "_timeout"}, timeout_err, tmo);
                chk({tag, "_stall_done"}, stall, 1'b0);
                chk({tag, "_stall_cnt"}, stall_cnt, exp_c);
                chk({tag, "_starts"}, starts, byp ? 0 : 1);
                chk({tag, "_dividend"}, dv_dividend, a);
                chk({tag, "_divisor"}, dv_divisor, b);
                chk({tag, "_signed"}, dv_signed, sgn);
            end else begin
                stall_cnt += stall;
                starts    += dv_start;
            end
        end
        chk({tag, "_we_seen"}, seen, 1'b1);
        div_req  = 1'b0;
        divu_req = 1'b0;
        if (tmo) wait_div_free();
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        sgn;
        int          lat;
        logic [31:0] ehi, elo;
        string       tag;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int start_c, we_c;
        vecs[0] = '{32'd100,        32'd7,          1'b0, 33, 32'd2,          32'd14,         "u100_7"};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 10, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  "s_m7_2"};
        vecs[2] = '{32'd20,         32'hFFFF_FFFD,  1'b1, 4,  32'd2,          32'hFFFF_FFFA,  "s20_m3"};
        vecs[3] = '{32'hFFFF_FFFF,  32'd16,         1'b0, 1,  32'h0000_000F,  32'h0FFF_FFFF,  "u_lat1"};
        vecs[4] = '{32'd1000,       32'd3,          1'b0, 47, 32'd1,          32'd333,        "lat47"};
        vecs[5] = '{32'd1000,       32'd3,          1'b0, 48, 32'd0,          32'd0,          "lat48_to"};
        vecs[6] = '{32'd5,          32'd0,          1'b0, 6,  32'd5,          32'hFFFF_FFFF,  "rt0"};
        vecs[7] = '{32'hFFFF_FFF0,  32'hFFFF_FFFC,  1'b1, 2,  32'd0,          32'd4,          "s_m16_m4"};

        rst = 1'b1; div_req = 1'b0; divu_req = 1'b0; flush = 1'b0;
        rs_val = '0; rt_val = '0;
        @(negedge clk);
        chk("rst_we", hilo_we, 1'b0);
        chk("rst_start", dv_start, 1'b0);
        chk("rst_to", timeout_err, 1'b0);
        chk("rst_hi", hi_wdata, 32'd0);
        chk("rst_lo", lo_wdata, 32'd0);
        chk("rst_stall_noreq", stall, 1'b0);
        divu_req = 1'b1;
        #1 chk("rst_stall_req", stall, 1'b1);
        divu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].lat, 1'b1, vecs[i].ehi, vecs[i].elo, 1'b0, vecs[i].tag);

        // flush in the 10th WAIT cycle; retry only once the abandoned divide drops busy
        @(negedge clk);
        div_lat = 30; rs_val = 32'd1000; rt_val = 32'd9; divu_req = 1'b1;
        start_c = 0; we_c = 0;
        for (int c = 1; c <= 80 && we_c == 0; c++) begin
            @(negedge clk);
            if (c == 11) begin
                flush = 1'b1;
                #1;
                chk("flush_stall", stall, 1'b0);
                chk("flush_we", hilo_we, 1'b0);
            end else if (c == 12) begin
                flush = 1'b0;
                div_lat = 5;
                #1;
                chk("flush_idle_stall", stall, 1'b1);
                chk("flush_idle_start", dv_start, 1'b0);
            end else begin
                if (c > 12 && dv_start && start_c == 0) start_c = c;
                if (hilo_we) we_c = c;
            end
        end
        chk("flush_restart_cycle", start_c, 32);
        chk("flush_we_cycle", we_c, 38);
        chk("flush_lo", lo_wdata, 32'd111);
        chk("flush_hi", hi_wdata, 32'd1);
        divu_req = 1'b0;

        // divider stuck busy past the watchdog
        do_op(32'd50, 32'd5, 1'b0, 200, 1'b1, 32'd0, 32'd10, 1'b0, "stuck");

        // two requests back to back
        do_op(32'd77, 32'd5, 1'b0, 8, 1'b1, 32'd2, 32'd15, 1'b0, "b2b_first");
        do_op(32'd90, 32'd4, 1'b0, 3, 1'b1, 32'd2, 32'd22, 1'b1, "b2b_second");

        // reset in the middle of WAIT
        @(negedge clk);
        div_lat = 30; rs_val = 32'd500; rt_val = 32'd7; divu_req = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", hilo_we, 1'b0);
        chk("mid_rst_start", dv_start, 1'b0);
        chk("mid_rst_to", timeout_err, 1'b0);
        chk("mid_rst_hi", hi_wdata, 32'd0);
        chk("mid_rst_lo", lo_wdata, 32'd0);
        chk("mid_rst_dividend", dv_dividend, 32'd0);
        chk("mid_rst_stall", stall, 1'b1);
        divu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        we_c = 0; start_c = 0;
        repeat (40) begin
            @(negedge clk);
            we_c    += hilo_we;
            start_c += dv_start;
        end
        chk("post_rst_we", we_c, 0);
        chk("post_rst_start", start_c, 0);

        for (int i = 0; i < 25; i++) begin
            logic [31:0] a, b;
            logic        sgn;
            a   = $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom_range(1, 300) : $urandom);
            sgn = $urandom_range(0, 1);
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            do_op(a, b, sgn, $urandom_range(1, 50), 1'b0, 32'd0, 32'd0, 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
